// File: rtl/matrix_result_unloader.sv
// Waits for all enabled cores to finish, then streams a block of data-memory words
// out on a valid/ready interface through a credit-controlled output FIFO.
module matrix_result_unloader #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int NUM_CORES  = 4,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] core_en,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W-1:0]    word_count,
  input  logic [NUM_CORES-1:0] end_process,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 1);

  typedef enum logic [2:0] {IDLE, WAIT_END, READ, DRAIN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [NUM_CORES-1:0]   core_en_q;
  logic [CNT_W-1:0]       word_count_q;
  logic [ADDR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]       issued;
  logic [CNT_W-1:0]       sent;
  logic [RD_LAT-1:0]      rd_vld_p;
  logic [DATA_W-1:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_idx;
  logic [PTR_W-1:0]       rd_idx;
  logic [OCC_W-1:0]       fifo_count;
  logic [OCC_W-1:0]       inflight;
  logic                   wait_ok;
  logic                   credit_ok;
  logic                   issue;
  logic                   fifo_wr;
  logic                   fifo_empty;
  logic                   pop;

  assign wait_ok    = ((end_process & core_en_q) == core_en_q);
  assign fifo_empty = (fifo_count == '0);
  assign pop        = !fifo_empty && out_ready;
  assign fifo_wr    = rd_vld_p[RD_LAT-1];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + OCC_W'(rd_vld_p[i]);
    end
  end

  // Reads still in the memory pipeline already own a FIFO slot
  assign credit_ok = (fifo_count + inflight) < OCC_W'(FIFO_DEPTH);
  assign issue     = (state == READ) && (issued < word_count_q) && credit_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = WAIT_END;
      WAIT_END: if (wait_ok) state_nxt = (word_count_q == '0) ? DONE : READ;
      READ:     if ((issued == word_count_q) ||
                    (issue && (issued + CNT_W'(1) == word_count_q))) state_nxt = DRAIN;
      DRAIN:    if (sent == word_count_q) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = issue;
    mem_addr  = rd_ptr;
    out_valid = !fifo_empty;
    out_data  = fifo_empty ? '0 : fifo_mem[rd_idx];
    out_last  = !fifo_empty && (sent + CNT_W'(1) == word_count_q);
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_en_q    <= '0;
      word_count_q <= '0;
      rd_ptr       <= '0;
      issued       <= '0;
      sent         <= '0;
    end else if ((state == IDLE) && start) begin
      core_en_q    <= core_en;
      word_count_q <= {1'b0, word_count};
      rd_ptr       <= base_addr;
      issued       <= '0;
      sent         <= '0;
    end else begin
      if (issue) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
        issued <= issued + CNT_W'(1);
      end
      if (pop) begin
        sent <= sent + CNT_W'(1);
      end
    end
  end

  // p0..pN: read-valid tracking matching the memory latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_p <= '0;
    end else begin
      rd_vld_p[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld_p[i] <= rd_vld_p[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem[wr_idx] <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx     <= '0;
      rd_idx     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_wr) begin
        wr_idx <= (wr_idx == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_idx + PTR_W'(1);
      end
      if (pop) begin
        rd_idx <= (rd_idx == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_idx + PTR_W'(1);
      end
      case ({fifo_wr, pop})
        2'b10:   fifo_count <= fifo_count + OCC_W'(1);
        2'b01:   fifo_count <= fifo_count - OCC_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_unloader.sv
// Directed bench for matrix_result_unloader with a 1-cycle-latency memory model.
module tb_matrix_result_unloader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  core_en = '0;
  logic [7:0]  base_addr = '0;
  logic [7:0]  word_count = '0;
  logic [3:0]  end_process = '0;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata = '0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        busy;
  logic        done;

  matrix_result_unloader #(
    .ADDR_W(8), .DATA_W(16), .NUM_CORES(4), .RD_LAT(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .core_en(core_en),
    .base_addr(base_addr), .word_count(word_count), .end_process(end_process),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic [7:0]  addr_q [$];
  int          rd_cyc_q [$];
  logic [15:0] data_q [$];
  logic        last_q [$];
  int          out_cyc_q [$];
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          valid_cnt = 0;
  int          stab_err = 0;
  logic        stall_prev = 1'b0;
  logic [15:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_en) begin addr_q.push_back(mem_addr); rd_cyc_q.push_back(cyc); end
      if (out_valid && out_ready) begin
        data_q.push_back(out_data); last_q.push_back(out_last); out_cyc_q.push_back(cyc);
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (out_valid) valid_cnt++;
      if (stall_prev && (!out_valid || out_data !== prev_data)) stab_err++;
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task clear_logs();
    addr_q.delete(); rd_cyc_q.delete(); data_q.delete(); last_q.delete(); out_cyc_q.delete();
    valid_cnt = 0; stab_err = 0;
  endtask

  task start_unload(input logic [3:0] ce, input logic [7:0] ba, input logic [7:0] wc,
                    output int scyc);
    @(posedge clk); #1;
    start = 1'b1; core_en = ce; base_addr = ba; word_count = wc; scyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; core_en = 4'hF; base_addr = 8'h55; word_count = 8'h77;
  endtask

  task wait_done(input int budget, output int dcyc);
    int n;
    n = 0; dcyc = -1;
    while (n < budget && dcyc < 0) begin
      @(negedge clk);
      if (done === 1'b1) dcyc = cyc;
      n++;
    end
    total++;
    if (dcyc < 0) begin bad++; $display("FAIL done_timeout got=none want=pulse within %0d cycles", budget); end
    @(posedge clk); #1;
  endtask

  task test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({mem_rd_en, out_valid, out_last, busy, done} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=00000", {mem_rd_en, out_valid, out_last, busy, done});
    end
    total++;
    if ({mem_addr, out_data} !== 24'h0) begin
      bad++; $display("FAIL reset_data got=%h want=000000", {mem_addr, out_data});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task test_basic();
    int scyc, ep_cyc, dcyc, d0;
    clear_logs(); d0 = done_cnt;
    out_ready = 1'b1; end_process = 4'b0000;
    start_unload(4'b0001, 8'h20, 8'd4, scyc);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (addr_q.size() != 0) begin bad++; $display("FAIL basic_wait_noread got=%0d want=0", addr_q.size()); end
    end_process = 4'b0001; ep_cyc = cyc;
    wait_done(40, dcyc);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b want=0", busy); end
    total++;
    if (done_cnt != d0 + 1) begin bad++; $display("FAIL basic_done_count got=%0d want=%0d", done_cnt - d0, 1); end
    total++;
    if (addr_q.size() != 4 || data_q.size() != 4) begin
      bad++; $display("FAIL basic_sizes got=%0d/%0d want=4/4", addr_q.size(), data_q.size());
    end else begin
      total++;
      if (rd_cyc_q[0] != ep_cyc + 1) begin bad++; $display("FAIL basic_first_read got=%0d want=%0d", rd_cyc_q[0], ep_cyc + 1); end
      total++;
      if (out_cyc_q[0] != rd_cyc_q[0] + 2) begin bad++; $display("FAIL basic_first_valid got=%0d want=%0d", out_cyc_q[0], rd_cyc_q[0] + 2); end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (addr_q[i] !== 8'h20 + 8'(i) || rd_cyc_q[i] != rd_cyc_q[0] + i) begin
          bad++; $display("FAIL basic_addr%0d got=%h@%0d want=%h@%0d", i, addr_q[i], rd_cyc_q[i], 8'h20 + 8'(i), rd_cyc_q[0] + i);
        end
        total++;
        if (data_q[i] !== 16'(i + 1)) begin bad++; $display("FAIL basic_data%0d got=%h want=%h", i, data_q[i], 16'(i + 1)); end
        total++;
        if (last_q[i] !== (i == 3)) begin bad++; $display("FAIL basic_last%0d got=%b want=%b", i, last_q[i], i == 3); end
      end
    end
    end_process = 4'b0000;
  endtask

  task test_multicore();
    int scyc, ep_cyc, dcyc;
    clear_logs();
    out_ready = 1'b1; end_process = 4'b0000;
    start_unload(4'b1010, 8'h40, 8'd2, scyc);
    end_process = 4'b0010;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (addr_q.size() != 0) begin bad++; $display("FAIL multi_gated got=%0d reads want=0", addr_q.size()); end
    end_process = 4'b1010; ep_cyc = cyc;
    wait_done(40, dcyc);
    total++;
    if (data_q.size() != 2 || rd_cyc_q.size() == 0) begin
      bad++; $display("FAIL multi_sizes got=%0d want=2", data_q.size());
    end else begin
      total++;
      if (rd_cyc_q[0] != ep_cyc + 1) begin bad++; $display("FAIL multi_first_read got=%0d want=%0d", rd_cyc_q[0], ep_cyc + 1); end
      total++;
      if (data_q[0] !== mem[8'h40] || data_q[1] !== mem[8'h41]) begin
        bad++; $display("FAIL multi_data got=%h,%h want=%h,%h", data_q[0], data_q[1], mem[8'h40], mem[8'h41]);
      end
    end
    end_process = 4'b0000;
  endtask

  task test_backpressure();
    int scyc, d0, n;
    clear_logs(); d0 = done_cnt;
    out_ready = 1'b0; end_process = 4'b0001;
    start_unload(4'b0001, 8'h60, 8'd8, scyc);
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (addr_q.size() != 4) begin bad++; $display("FAIL bp_credit_reads got=%0d want=4", addr_q.size()); end
    total++;
    if (out_valid !== 1'b1 || out_data !== mem[8'h60] || out_last !== 1'b0) begin
      bad++; $display("FAIL bp_head got=v%b d%h l%b want=v1 d%h l0", out_valid, out_data, out_last, mem[8'h60]);
    end
    n = 0;
    while (n < 100 && done_cnt == d0) begin
      @(posedge clk); #1;
      out_ready = ~out_ready;
      n++;
    end
    total++;
    if (done_cnt != d0 + 1) begin bad++; $display("FAIL bp_done got=%0d want=1", done_cnt - d0); end
    total++;
    if (stab_err != 0) begin bad++; $display("FAIL bp_stable got=%0d violations want=0", stab_err); end
    total++;
    if (data_q.size() != 8) begin
      bad++; $display("FAIL bp_count got=%0d want=8", data_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (data_q[i] !== mem[8'h60 + 8'(i)] || last_q[i] !== (i == 7)) begin
          bad++; $display("FAIL bp_word%0d got=%h/%b want=%h/%b", i, data_q[i], last_q[i], mem[8'h60 + 8'(i)], i == 7);
        end
      end
    end
    out_ready = 1'b1; end_process = 4'b0000;
    @(posedge clk); #1;
  endtask

  task test_wrap_zero();
    int scyc, dcyc;
    clear_logs();
    out_ready = 1'b1; end_process = 4'b0001;
    start_unload(4'b0001, 8'hFE, 8'd3, scyc);
    wait_done(40, dcyc);
    total++;
    if (addr_q.size() != 3 || data_q.size() != 3) begin
      bad++; $display("FAIL wrap_sizes got=%0d/%0d want=3/3", addr_q.size(), data_q.size());
    end else begin
      total++;
      if (addr_q[0] !== 8'hFE || addr_q[1] !== 8'hFF || addr_q[2] !== 8'h00) begin
        bad++; $display("FAIL wrap_addr got=%h,%h,%h want=fe,ff,00", addr_q[0], addr_q[1], addr_q[2]);
      end
      total++;
      if (data_q[2] !== mem[0] || data_q[0] !== mem[8'hFE]) begin
        bad++; $display("FAIL wrap_data got=%h,%h want=%h,%h", data_q[0], data_q[2], mem[8'hFE], mem[0]);
      end
    end
    clear_logs();
    start_unload(4'b0001, 8'h10, 8'd0, scyc);
    wait_done(20, dcyc);
    total++;
    if (dcyc != scyc + 2) begin bad++; $display("FAIL zero_done_cycle got=%0d want=%0d", dcyc, scyc + 2); end
    total++;
    if (addr_q.size() != 0 || valid_cnt != 0) begin
      bad++; $display("FAIL zero_activity got=%0d reads %0d valids want=0 0", addr_q.size(), valid_cnt);
    end
    end_process = 4'b0000;
  endtask

  task test_reset_abort();
    int scyc, d0, n, dcyc;
    clear_logs();
    out_ready = 1'b1; end_process = 4'b0001;
    start_unload(4'b0001, 8'h80, 8'd8, scyc);
    n = 0;
    while (n < 40 && data_q.size() < 2) begin @(negedge clk); n++; end
    total++;
    if (data_q.size() < 2) begin bad++; $display("FAIL abort_progress got=%0d want=2", data_q.size()); end
    @(posedge clk); #1;
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    total++;
    if ({mem_rd_en, out_valid, out_last, busy, done, mem_addr, out_data} !== 29'h0) begin
      bad++; $display("FAIL abort_outputs got=%h want=0", {mem_rd_en, out_valid, out_last, busy, done, mem_addr, out_data});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (done_cnt != d0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL abort_idle got=done%0d busy%b valid%b want=0 0 0", done_cnt - d0, busy, out_valid);
    end
    clear_logs();
    end_process = 4'b0000;
    start_unload(4'b0001, 8'hA0, 8'd3, scyc);
    @(posedge clk); #1;
    start = 1'b1; core_en = 4'b0010; base_addr = 8'hC0; word_count = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    end_process = 4'b0001;
    wait_done(40, dcyc);
    total++;
    if (addr_q.size() != 3) begin
      bad++; $display("FAIL ignstart_count got=%0d want=3", addr_q.size());
    end else begin
      total++;
      if (addr_q[0] !== 8'hA0 || addr_q[2] !== 8'hA2 || data_q.size() != 3) begin
        bad++; $display("FAIL ignstart_cfg got=%h..%h n%0d want=a0..a2 n3", addr_q[0], addr_q[2], data_q.size());
      end
    end
    end_process = 4'b0000;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'hC3 ^ 8'(i), 8'(i)};
    mem[8'h20] = 16'd1; mem[8'h21] = 16'd2; mem[8'h22] = 16'd3; mem[8'h23] = 16'd4;
    test_reset();
    test_basic();
    test_multicore();
    test_backpressure();
    test_wrap_zero();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_result_unloader.md
Name: matrix_result_unloader

Overview:
- Downstream stage of the multi-core processor. It waits until every enabled core has raised its end_process bit.
- It then reads the result matrix out of one data-memory port, using a base address and word count latched at start.
- Words leave on a valid/ready stream that feeds the host/readback path.
- An internal FIFO absorbs memory read latency and downstream backpressure, so no data word is ever lost or duplicated.

Parameters:
- ADDR_W, 8: data-memory address width.
- DATA_W, 16: data-memory word width.
- NUM_CORES, 4: width of end_process and core_en.
- RD_LAT, 1: data-memory read latency in cycles, from address presented to mem_rdata valid.
- FIFO_DEPTH, 4: output FIFO entries; must be >= RD_LAT+1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle arm pulse; honoured only in IDLE.
- core_en  in  NUM_CORES  cores that must finish; sampled on start.
- base_addr  in  ADDR_W  first result address; sampled on start.
- word_count  in  ADDR_W  number of words to unload; sampled on start.
- end_process  in  NUM_CORES  per-core completion flags from processor.
- mem_rd_en  out  1  read strobe to data-memory port.
- mem_addr  out  ADDR_W  read address.
- mem_rdata  in  DATA_W  read data, valid RD_LAT cycles after mem_rd_en.
- out_data  out  DATA_W  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready from consumer.
- out_last  out  1  marks the final word of the unload.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the unload completes.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE; FIFO is emptied; in-flight read tracking is cleared.
  - Outputs: mem_rd_en=0, mem_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
  - Reset mid-unload aborts immediately. No partial done is produced, and any returning mem_rdata is discarded.
- States: IDLE, WAIT_END, READ, DRAIN, DONE.
- IDLE:
  - On start=1, latch core_en, base_addr and word_count.
  - Set rd_ptr=base_addr, issued=0, sent=0, then go to WAIT_END.
  - If start arrives in any other state, it is ignored.
- WAIT_END:
  - Leave when (end_process & core_en_q) == core_en_q.
  - core_en_q=0 satisfies the condition immediately.
  - If word_count_q=0, go to DONE; otherwise go to READ.
  - No reads are issued in WAIT_END.
- READ:
  - mem_rd_en=1 in any cycle where issued < word_count_q and (fifo_count + inflight) < FIFO_DEPTH.
  - mem_addr=rd_ptr. On each issue, rd_ptr increments modulo 2^ADDR_W (wraps 255 -> 0) and issued increments.
  - mem_rdata is written into the FIFO exactly RD_LAT cycles after the matching mem_rd_en.
  - Go to DRAIN once issued == word_count_q.
  - First mem_rd_en occurs the cycle after the WAIT_END condition is seen.
  - First out_valid occurs RD_LAT+1 cycles after the first mem_rd_en.
- DRAIN: no reads issued; go to DONE when sent == word_count_q.
- Stream rules:
  - out_valid = FIFO not empty; out_data = FIFO head.
  - A transfer happens when out_valid and out_ready are both 1; sent then increments.
  - Once asserted, out_valid and out_data must hold stable until the transfer.
  - out_last=1 exactly when out_valid=1 and the head is word index word_count_q-1.
  - The FIFO may write and pop in the same cycle; occupancy is then unchanged.
  - The credit rule guarantees the FIFO never overflows.
- DONE: done=1 for one cycle, then go to IDLE. busy is already 0 in that IDLE cycle.
- end_process changing after WAIT_END has been exited is ignored.
- Counters are ADDR_W+1 bits wide, so word_count=255 completes correctly.

Test Plan:
- Basic unload: core_en=4'b0001, base_addr=8'h20, word_count=4, mem[20..23]=1,2,3,4, out_ready=1; raise end_process[0] -> reads at 20..23 on consecutive cycles; stream 1,2,3,4 with out_last on 4; done pulses once; busy low after.
- Multi-core gating: core_en=4'b1010, word_count=2; assert end_process=4'b0010, then 4'b1010 ten cycles later -> no mem_rd_en until the second assertion; first read the following cycle.
- Backpressure: word_count=8, out_ready held 0 -> exactly FIFO_DEPTH reads issued, then stall; toggle out_ready 1/0 -> all 8 words in order, none lost or duplicated, out_valid/out_data stable while stalled.
- Address wrap and zero length: base_addr=8'hFE, word_count=3 -> addresses FE, FF, 00. Then word_count=0 with end_process ready -> no reads, no out_valid, done one cycle after WAIT_END.
- Reset and ignored start: rst_n low for 1 cycle after the 2nd word of an 8-word unload -> all outputs 0 immediately, no done. A start pulse issued during a busy unload -> ignored, and the latched config is unchanged.
